// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, FSM encoding and word helpers.
package aes_pkg;

    localparam int NK       = 4;
    localparam int NR       = 10;
    localparam int WORD_LEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } ke_state_t;

    // Round constant for round i (1..10); other indices never occur.
    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Cyclic left rotate of a word by one byte.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/key_expansion_ctrl_sub_word.sv
// SubWord: byte-wise AES S-box with a one-cycle registered latency.
// The S-box is computed as GF(2^8) inverse followed by the affine map.
module key_expansion_ctrl_sub_word #(
    parameter int DATA_LEN     = 32,
    parameter int NUM_OF_BYTES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    input  logic [DATA_LEN-1:0] data_in,
    output logic                valid_out,
    output logic [DATA_LEN-1:0] data_out
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse (and maps 0 to 0).
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    logic [DATA_LEN-1:0] sub;

    for (genvar g = 0; g < NUM_OF_BYTES; g++) begin : g_byte
        assign sub[g*8 +: 8] = sbox(data_in[g*8 +: 8]);
    end

    // Capture the substituted word whenever a request arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) data_out <= sub;
        end
    end

endmodule

// File: rtl/key_expansion_ctrl.sv
// AES-128 key schedule sequencer around one shared SubWord unit.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; outputs hold the last round key
// ST_ISSUE | current round key presented; SubWord request unless last
// ST_WAIT  | waiting for SubWord result to build the next round key
module key_expansion_ctrl
    import aes_pkg::*;
#(
    parameter int KEY_LEN    = 128,
    parameter int WORD_LEN   = 32,
    parameter int NUM_ROUNDS = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [KEY_LEN-1:0] key_in,
    output logic               busy,
    output logic               rk_valid,
    output logic [3:0]         rk_index,
    output logic [KEY_LEN-1:0] rk_out,
    output logic               done
);

    ke_state_t           state, state_d;
    logic [KEY_LEN-1:0]  key_reg, key_d;
    logic [3:0]          round, round_d;
    logic                sw_valid_in, sw_valid_out;
    logic [WORD_LEN-1:0] sw_data_in, sw_data_out;
    logic [31:0]         t, w0n, w1n, w2n, w3n;

    key_expansion_ctrl_sub_word #(
        .DATA_LEN    (WORD_LEN),
        .NUM_OF_BYTES(4)
    ) u_sub_word (
        .clk      (clk),
        .reset    (~reset),
        .valid_in (sw_valid_in),
        .data_in  (sw_data_in),
        .valid_out(sw_valid_out),
        .data_out (sw_data_out)
    );

    // Next-state, next key/round and SubWord request.
    always_comb begin
        state_d     = state;
        key_d       = key_reg;
        round_d     = round;
        sw_valid_in = 1'b0;
        sw_data_in  = rot_word(key_reg[31:0]);
        t   = sw_data_out ^ {rcon(round + 4'd1), 24'h0};
        w0n = key_reg[127:96] ^ t;
        w1n = key_reg[95:64]  ^ w0n;
        w2n = key_reg[63:32]  ^ w1n;
        w3n = key_reg[31:0]   ^ w2n;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    round_d = 4'd0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (round == 4'(NUM_ROUNDS)) begin
                    state_d = ST_IDLE;
                end else begin
                    sw_valid_in = 1'b1;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sw_valid_out) begin
                    key_d   = {w0n, w1n, w2n, w3n};
                    round_d = round + 4'd1;
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers and outputs, registered on entry to the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            key_reg  <= '0;
            round    <= 4'd0;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            rk_index <= 4'd0;
            rk_out   <= '0;
            done     <= 1'b0;
        end else begin
            state   <= state_d;
            key_reg <= key_d;
            round   <= round_d;
            busy    <= (state_d != ST_IDLE);
            if (state_d == ST_ISSUE) begin
                rk_valid <= 1'b1;
                rk_out   <= key_d;
                rk_index <= round_d;
                done     <= (round_d == 4'(NUM_ROUNDS));
            end else begin
                rk_valid <= 1'b0;
                done     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Scoreboard bench for key_expansion_ctrl with a table-driven key schedule model.
module tb_key_expansion_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key_in;
    logic         busy, rk_valid, done;
    logic [3:0]   rk_index;
    logic [127:0] rk_out;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    typedef struct {
        int           idx;
        logic [127:0] key;
        logic         dn;
        int           when;
    } exp_t;
    exp_t q[$];

    logic [127:0] last_key;

    logic [7:0] sb [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };
    logic [7:0] rcon_t [1:10] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

    key_expansion_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .key_in  (key_in),
        .busy    (busy),
        .rk_valid(rk_valid),
        .rk_index(rk_index),
        .rk_out  (rk_out),
        .done    (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Round key r from round key r-1, straight from the key schedule definition.
    function automatic logic [127:0] model_next(input logic [127:0] k, input int r);
        logic [31:0] w [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        t = {sb[w[3][23:16]], sb[w[3][15:8]], sb[w[3][7:0]], sb[w[3][31:24]]}
            ^ {rcon_t[r], 24'h0};
        w[0] = w[0] ^ t;
        for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i-1];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic push_run(input logic [127:0] key, input int a, input bit ovr,
                            input logic [127:0] k1, input logic [127:0] k10);
        logic [127:0] k;
        exp_t e;
        k = key;
        for (int r = 0; r <= 10; r++) begin
            e.idx  = r;
            e.key  = k;
            e.dn   = (r == 10);
            e.when = a + 2 * r;
            if (ovr && r == 1)  e.key = k1;
            if (ovr && r == 10) e.key = k10;
            q.push_back(e);
            last_key = e.key;
            if (r < 10) k = model_next(k, r + 1);
        end
    endtask

    // Monitor: every round-key strobe is popped and compared.
    always @(negedge clk) begin
        if (!reset) begin
            if (rk_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rk_valid", 128'(rk_index), 128'hffff);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rk_index", 128'(rk_index), 128'(e.idx));
                    chk("rk_out",   rk_out, e.key);
                    chk("done",     128'(done), 128'(e.dn));
                    chk("rk_time",  128'(cyc), 128'(e.when));
                end
            end else if (done) begin
                chk("done_without_valid", 128'(done), 128'(0));
            end
        end
    end

    task automatic do_start(input logic [127:0] key, input bit now, input bit ovr,
                            input logic [127:0] k1, input logic [127:0] k10);
        if (!now) @(negedge clk);
        start  = 1'b1;
        key_in = key;
        push_run(key, cyc + 1, ovr, k1, k10);
        @(negedge clk);
        start  = 1'b0;
        key_in = rnd128();
        chk("busy_after_start", 128'(busy), 128'(1));
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 60 && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
            key_in = rnd128();
        end
        if (q.size() != 0) begin
            chk("run_timeout", 128'(q.size()), 128'(0));
            q.delete();
        end
        @(negedge clk);
        #1;
        chk("busy_after_done", 128'(busy), 128'(0));
        chk("hold_index",      128'(rk_index), 128'(10));
        chk("hold_key",        rk_out, last_key);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},     128'(busy), 128'(0));
        chk({tag, "_rk_valid"}, 128'(rk_valid), 128'(0));
        chk({tag, "_done"},     128'(done), 128'(0));
        chk({tag, "_rk_index"}, 128'(rk_index), 128'(0));
        chk({tag, "_rk_out"},   rk_out, 128'(0));
    endtask

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        key_in = '0;
        #1;
        chk_reset_vals("reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // FIPS-197 vector
        do_start(FIPS_KEY, 1'b0, 1'b1, FIPS_K1, FIPS_K10);
        wait_done();

        // all-zero key
        do_start(128'h0, 1'b0, 1'b1, ZERO_K1, ZERO_K10);
        wait_done();

        // second start during expansion is ignored
        do_start(FIPS_KEY, 1'b0, 1'b1, FIPS_K1, FIPS_K10);
        repeat (3) @(negedge clk);
        start  = 1'b1;
        key_in = rnd128();
        @(negedge clk);
        start  = 1'b0;
        wait_done();

        // back-to-back: start in the first cycle with busy low
        do_start(rnd128(), 1'b1, 1'b0, '0, '0);
        wait_done();

        // reset mid-expansion, then restart right at release
        do_start(rnd128(), 1'b0, 1'b0, '0, '0);
        repeat (6) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("abort");
        q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        do_start(FIPS_KEY, 1'b1, 1'b1, FIPS_K1, FIPS_K10);
        wait_done();

        // random keys
        for (int n = 0; n < 4; n++) begin
            do_start(rnd128(), 1'b0, 1'b0, '0, '0);
            wait_done();
        end

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
